layer_mem_arbiter: RTL
======================

# layer_mem_arbiter

Two-requester arbiter that shares the single layer-memory port (cwr/crd/csel/caddr/cdata) between the atrous-convolution engine (requester 0) and the host readback/DMA path (requester 1). It issues one memory operation per cycle, using round-robin fairness with an optional bounded lock for bursts. Read data is returned to the owning requester with a fixed latency. It sits between both requesters and the layer-0/layer-1 memory model.

## Interface
- AW, 12, address width (64x64 map)
- DW, 13, data width (signed Q9.4 layer data)
- LOCK_MAX, 16, maximum consecutive locked grants to one requester while the other is requesting
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-low; sampled on rising edge of clk
- rN_req  in  1  requester N (N=0,1) command valid; command fields held stable until granted
- rN_we  in  1  1 = write, 0 = read
- rN_sel  in  1  memory select (0 = layer 0, 1 = layer 1), driven to csel
- rN_addr  in  AW  address
- rN_wdata  in  DW  write data
- rN_lock  in  1  request to keep ownership for the next cycle
- rN_gnt  out  1  combinational grant; command accepted at this rising edge
- rN_rvalid  out  1  one-cycle read-return strobe
- rN_rdata  out  DW  read data, valid while rN_rvalid
- cwr  out  1  memory write strobe (registered)
- caddr_wr  out  AW  write address
- cdata_wr  out  DW  write data
- crd  out  1  memory read strobe (registered)
- caddr_rd  out  AW  read address
- cdata_rd  in  DW  memory read data, valid the cycle after crd
- csel  out  1  memory select for the issued operation

## Operation
- At most one of r0_gnt/r1_gnt is high per cycle. A grant is issued only when the corresponding rN_req is high.
- FSM states:
  - ARB: no owner. Transitions: ARB -> LOCKn when granted rn_lock=1 (lock feature compiled in). LOCKn -> ARB when the owner deasserts req or lock, or when the lock counter reaches LOCK_MAX while the other requester is requesting.
  - LOCK0: owner is requester 0.
  - LOCK1: owner is requester 1.
- ARB policy:
  - Only one requester requesting: it is granted.
  - Both requesting: the requester not served last wins (rr pointer).
  - The pointer updates to the granted index on every grant.
- LOCKn policy: owner n is granted whenever it requests. Lock counter:
  - Increments per locked grant.
  - Resets to 0 on entering ARB.
  - On hitting LOCK_MAX with the other side requesting, the next grant goes to the other side.
- Issue: on an accepted command, the next cycle drives:
  - write: cwr=1, caddr_wr, cdata_wr, csel.
  - read: crd=1, caddr_rd, csel.
  - cwr and crd are never both 1.
- Read return: a 2-entry tag pipeline records the owner of each issued read. cdata_rd is captured the cycle after crd; the tagged rN_rvalid pulses one cycle later. Other requester's rvalid stays 0.
- Write data and addresses are passed through unmodified; no arithmetic on data.
- When idle, cwr=crd=0. Address/data/csel outputs hold their last values.

## Timing
- Grant: combinational from req/lock/state in the same cycle.
- Memory strobes: cycle N+1 after acceptance in cycle N.
- Read latency: accept at N, crd at N+1, cdata_rd at N+2, rN_rvalid/rN_rdata at N+3.
- Back-to-back: one accepted command per cycle; reads may be pipelined every cycle, interleaved across requesters, returns in issue order.
- Reset (reset=0 at a rising edge):
  - Outputs: all outputs 0 (rN_gnt=0 regardless of req, cwr=crd=0, csel=0, addresses/data 0, rvalid 0).
  - Internal: FSM to ARB, rr pointer favours requester 0 first, lock counter 0.
  - In-flight reads are discarded, with no rvalid afterwards.
- Release from reset: a request present in the first cycle with reset=1 may be granted in that cycle.

## Configuration
- ARB_LOCK_EN defined:
  - LOCK0/LOCK1 states and the lock counter are present.
  - rN_lock is honoured with the LOCK_MAX bound.
- ARB_LOCK_EN undefined:
  - rN_lock is ignored and the FSM stays in ARB.
  - Pure round robin alternates grants every cycle when both request.

## Test plan
- Reset: reset=0 for 3 cycles with r0_req=r1_req=1 -> no gnt, cwr=crd=0, csel=0; first cycle after release, r0_gnt=1.
- Single write: r0 we=1, sel=1, addr=12'h041, wdata=13'h0A5 -> r0_gnt same cycle; next cycle cwr=1, caddr_wr=12'h041, cdata_wr=13'h0A5, csel=1.
- Read latency: r1 reads addr 12'hFFF, memory returns 13'h1F00 -> r1_rvalid=1 with r1_rdata=13'h1F00 exactly 3 cycles after r1_gnt; r0_rvalid stays 0.
- Round robin: both request continuously, no lock -> grants alternate r0,r1,r0,r1; 8 reads return in issue order to correct requester.
- Lock bound (ARB_LOCK_EN): r0 req+lock continuously, r1 req from cycle 0 -> 16 consecutive r0 grants, then r1 granted once.
- Reset mid-read: assert reset=0 one cycle after r0 read acceptance -> no r0_rvalid ever produced for that read.

Source files
------------

// File: rtl/layer_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : layer_mem_arbiter_if
// Description : Requester command/return bus plus the shared layer-memory port.
// Revision    : 1.0 - initial release
// ============================================================================
interface layer_mem_arbiter_if #(
    parameter int AW = 12,
    parameter int DW = 13
);
    logic          r0_req,    r1_req;
    logic          r0_we,     r1_we;
    logic          r0_sel,    r1_sel;
    logic [AW-1:0] r0_addr,   r1_addr;
    logic [DW-1:0] r0_wdata,  r1_wdata;
    logic          r0_lock,   r1_lock;
    logic          r0_gnt,    r1_gnt;
    logic          r0_rvalid, r1_rvalid;
    logic [DW-1:0] r0_rdata,  r1_rdata;

    logic          cwr;
    logic [AW-1:0] caddr_wr;
    logic [DW-1:0] cdata_wr;
    logic          crd;
    logic [AW-1:0] caddr_rd;
    logic [DW-1:0] cdata_rd;
    logic          csel;

    modport slave (
        input  r0_req, r0_we, r0_sel, r0_addr, r0_wdata, r0_lock,
        input  r1_req, r1_we, r1_sel, r1_addr, r1_wdata, r1_lock,
        output r0_gnt, r0_rvalid, r0_rdata,
        output r1_gnt, r1_rvalid, r1_rdata,
        output cwr, caddr_wr, cdata_wr, crd, caddr_rd, csel,
        input  cdata_rd
    );

    modport master (
        output r0_req, r0_we, r0_sel, r0_addr, r0_wdata, r0_lock,
        output r1_req, r1_we, r1_sel, r1_addr, r1_wdata, r1_lock,
        input  r0_gnt, r0_rvalid, r0_rdata,
        input  r1_gnt, r1_rvalid, r1_rdata,
        input  cwr, caddr_wr, cdata_wr, crd, caddr_rd, csel,
        output cdata_rd
    );
endinterface
`default_nettype wire

// File: rtl/layer_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : layer_mem_arbiter
// Description : Round-robin arbiter sharing the layer-memory port between the
//               convolution engine (r0) and host path (r1). Define ARB_LOCK_EN
//               to enable bounded lock ownership for bursts.
// Revision    : 1.0 - initial release
// ============================================================================
module layer_mem_arbiter #(
    parameter int AW       = 12,
    parameter int DW       = 13,
    parameter int LOCK_MAX = 16
) (
    input  logic               clk,
    input  logic               reset,
    layer_mem_arbiter_if.slave bus
);
    logic          gnt0, gnt1;
    logic          arb_g0, arb_g1;
    logic          rr_q, rr_d;
    logic          cwr_q, cwr_d, crd_q, crd_d, csel_q, csel_d;
    logic [AW-1:0] caddr_wr_q, caddr_wr_d, caddr_rd_q, caddr_rd_d;
    logic [DW-1:0] cdata_wr_q, cdata_wr_d;
    logic          rd_id1_q, rd_id1_d, rd_v2_q, rd_v2_d, rd_id2_q, rd_id2_d;
    logic          rv_q, rv_d, rv_id_q, rv_id_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          cmd_we, cmd_sel;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;

    // rr_q holds the index served last, so the other side wins a tie.
    always_comb begin
        arb_g0 = bus.r0_req && (!bus.r1_req || rr_q);
        arb_g1 = bus.r1_req && (!bus.r0_req || !rr_q);
    end

`ifdef ARB_LOCK_EN
    localparam int CNT_W = $clog2(LOCK_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_MAX);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             hold;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gnt0    = 1'b0;
        gnt1    = 1'b0;
        case (state_q)
            LOCK0:   hold = bus.r0_req && bus.r0_lock && !(cnt_q == CNT_MAX && bus.r1_req);
            LOCK1:   hold = bus.r1_req && bus.r1_lock && !(cnt_q == CNT_MAX && bus.r0_req);
            default: hold = 1'b0;
        endcase
        if (hold) begin
            gnt0 = (state_q == LOCK0);
            gnt1 = (state_q == LOCK1);
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_ONE;
        end else begin
            // Releasing a lock arbitrates in the same cycle; rr_q already
            // points away from the old owner, so the waiting side wins.
            gnt0    = arb_g0;
            gnt1    = arb_g1;
            state_d = ARB;
            cnt_d   = '0;
            if (arb_g0 && bus.r0_lock) begin
                state_d = LOCK0;
                cnt_d   = CNT_ONE;
            end else if (arb_g1 && bus.r1_lock) begin
                state_d = LOCK1;
                cnt_d   = CNT_ONE;
            end
        end
        if (!reset) begin
            gnt0 = 1'b0;
            gnt1 = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ARB;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end
`else
    logic unused_lock;
    assign unused_lock = bus.r0_lock ^ bus.r1_lock ^ (LOCK_MAX == 0);

    always_comb begin
        gnt0 = arb_g0 && reset;
        gnt1 = arb_g1 && reset;
    end
`endif

    always_comb begin
        cmd_we     = gnt1 ? bus.r1_we    : bus.r0_we;
        cmd_sel    = gnt1 ? bus.r1_sel   : bus.r0_sel;
        cmd_addr   = gnt1 ? bus.r1_addr  : bus.r0_addr;
        cmd_wdata  = gnt1 ? bus.r1_wdata : bus.r0_wdata;
        rr_d       = rr_q;
        cwr_d      = 1'b0;
        crd_d      = 1'b0;
        csel_d     = csel_q;
        caddr_wr_d = caddr_wr_q;
        cdata_wr_d = cdata_wr_q;
        caddr_rd_d = caddr_rd_q;
        rd_id1_d   = rd_id1_q;
        if (gnt0 || gnt1) begin
            rr_d   = gnt1;
            csel_d = cmd_sel;
            if (cmd_we) begin
                cwr_d      = 1'b1;
                caddr_wr_d = cmd_addr;
                cdata_wr_d = cmd_wdata;
            end else begin
                crd_d      = 1'b1;
                caddr_rd_d = cmd_addr;
                rd_id1_d   = gnt1;
            end
        end
        // Owner tag follows the read through crd -> cdata_rd -> return.
        rd_v2_d  = crd_q;
        rd_id2_d = rd_id1_q;
        rv_d     = rd_v2_q;
        rv_id_d  = rd_id2_q;
        rdata_d  = rd_v2_q ? bus.cdata_rd : rdata_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rr_q       <= 1'b1;
            cwr_q      <= 1'b0;
            crd_q      <= 1'b0;
            csel_q     <= 1'b0;
            caddr_wr_q <= '0;
            cdata_wr_q <= '0;
            caddr_rd_q <= '0;
            rd_id1_q   <= 1'b0;
            rd_v2_q    <= 1'b0;
            rd_id2_q   <= 1'b0;
            rv_q       <= 1'b0;
            rv_id_q    <= 1'b0;
            rdata_q    <= '0;
        end else begin
            rr_q       <= rr_d;
            cwr_q      <= cwr_d;
            crd_q      <= crd_d;
            csel_q     <= csel_d;
            caddr_wr_q <= caddr_wr_d;
            cdata_wr_q <= cdata_wr_d;
            caddr_rd_q <= caddr_rd_d;
            rd_id1_q   <= rd_id1_d;
            rd_v2_q    <= rd_v2_d;
            rd_id2_q   <= rd_id2_d;
            rv_q       <= rv_d;
            rv_id_q    <= rv_id_d;
            rdata_q    <= rdata_d;
        end
    end

    assign bus.r0_gnt    = gnt0;
    assign bus.r1_gnt    = gnt1;
    assign bus.cwr       = cwr_q;
    assign bus.crd       = crd_q;
    assign bus.csel      = csel_q;
    assign bus.caddr_wr  = caddr_wr_q;
    assign bus.cdata_wr  = cdata_wr_q;
    assign bus.caddr_rd  = caddr_rd_q;
    assign bus.r0_rvalid = rv_q && !rv_id_q;
    assign bus.r1_rvalid = rv_q && rv_id_q;
    assign bus.r0_rdata  = rdata_q;
    assign bus.r1_rdata  = rdata_q;
endmodule
`default_nettype wire
